// File: rtl/zsync_pkg.sv
// Shared encodings for the memory-cycle phase generator and the clock-stall arbiter.
// Pure declarations; no logic, no latency.
package zsync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_STALL = 2'd2,
        ST_REL   = 2'd3
    } zst_state_t;

    localparam logic [1:0] CBEG      = 2'd0;
    localparam logic [1:0] POST_CBEG = 2'd1;
    localparam logic [1:0] PRE_CEND  = 2'd2;
    localparam logic [1:0] CEND      = 2'd3;

    // Owner index covers up to 8 requesters; cycle count covers TMO up to 255.
    localparam int OWN_W = 3;
    localparam int CNT_W = 8;

    function automatic logic [3:0] phase_dec(input logic [1:0] ph);
        return 4'b0001 << ph;
    endfunction

endpackage

// File: rtl/zstall_prio.sv
// Lowest-index-first priority encoder over the unmasked stall requests.
// Purely combinational, zero latency; no flow control.
module zstall_prio
    import zsync_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    output logic             o_any,
    output logic [OWN_W-1:0] o_idx
);

    always_comb begin
        o_any = |i_req;
        o_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = OWN_W'(i);
            end
        end
    end

endmodule

// File: rtl/zstall_sync.sv
// fclk-domain memory-cycle phase strobes plus a stall arbiter that moves zclk_stall only on cycle boundaries.
// Strobes are registered one edge after the counter; requesters hold their req level until served.
module zstall_sync #(
    parameter int NREQ = 4,
    parameter int TMO  = 255
) (
    input  logic            fclk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] stall_req,
    output logic [NREQ-1:0] stall_gnt,
    input  logic            clr_tmo,
    output logic            cbeg,
    output logic            post_cbeg,
    output logic            pre_cend,
    output logic            cend,
    output logic            zclk_stall,
    output logic            stall_tmo
);
    import zsync_pkg::*;

    logic [1:0]       r_phase;
    logic [3:0]       r_strb;
    zst_state_t       r_state;
    zst_state_t       w_state_nxt;
    logic [OWN_W-1:0] r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [NREQ-1:0]  r_mask;
    logic             r_tmo;

    logic             w_cend_edge;
    logic             w_any;
    logic             w_own_req;
    logic             w_tmo_hit;
    logic [OWN_W-1:0] w_prio_idx;
    logic [NREQ-1:0]  w_own_1h;
    logic [NREQ-1:0]  w_req_avail;

    assign w_req_avail = stall_req & ~r_mask;

    zstall_prio #(
        .NREQ (NREQ)
    ) u_prio (
        .i_req (w_req_avail),
        .o_any (w_any),
        .o_idx (w_prio_idx)
    );

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= CBEG;
            r_strb  <= '0;
        end else begin
            r_phase <= r_phase + 2'd1;
            r_strb  <= phase_dec(r_phase);
        end
    end

    assign cbeg      = r_strb[CBEG];
    assign post_cbeg = r_strb[POST_CBEG];
    assign pre_cend  = r_strb[PRE_CEND];
    assign cend      = r_strb[CEND];

    // Boundary edge: the one that raises cend, so stall changes line up with the cycle seam.
    assign w_cend_edge = (r_phase == CEND);

    always_comb begin
        w_own_1h = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_own_1h[i] = (r_owner == OWN_W'(i));
        end
    end

    assign w_own_req = |(stall_req & w_own_1h);

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any) begin
                r_owner <= w_prio_idx;
            end
            if (r_state != ST_STALL) begin
                r_cnt <= '0;
            end else if (w_cend_edge) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_mask <= (r_mask & stall_req) | (w_tmo_hit ? w_own_1h : '0);
            r_tmo  <= w_tmo_hit | (r_tmo & ~clr_tmo);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmo_hit   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A request already present on the boundary edge is granted at once.
                if (w_any) begin
                    w_state_nxt = w_cend_edge ? ST_STALL : ST_PEND;
                end
            end
            ST_PEND: begin
                if (!w_own_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cend_edge) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                if (w_cend_edge) begin
                    if (!w_own_req) begin
                        w_state_nxt = ST_REL;
                    end else if (r_cnt == CNT_W'(TMO - 1)) begin
                        w_state_nxt = ST_REL;
                        w_tmo_hit   = 1'b1;
                    end
                end
            end
            ST_REL: begin
                if (w_cend_edge) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        zclk_stall = (r_state == ST_STALL) || (r_state == ST_REL);
        stall_gnt  = (r_state == ST_STALL) ? w_own_1h : '0;
    end

    assign stall_tmo = r_tmo;

endmodule

// File: tb/tb_zstall_sync.sv
// Directed bench for zstall_sync with a cycle-level reference model and literal anchor checks.
module tb_zstall_sync;

    localparam int NREQ = 4;
    localparam int TMO  = 4;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_HOLD = 2;
    localparam int M_GAP  = 3;

    logic            fclk      = 1'b0;
    logic            rst_n     = 1'b0;
    logic            clr_tmo   = 1'b0;
    logic [NREQ-1:0] stall_req = '0;
    logic [NREQ-1:0] stall_gnt;
    logic            cbeg, post_cbeg, pre_cend, cend;
    logic            zclk_stall, stall_tmo;

    int n_tot  = 0;
    int n_pass = 0;

    int              m_n    = 0;
    int              m_mode = M_IDLE;
    int              m_own  = 0;
    int              m_cyc  = 0;
    logic [NREQ-1:0] m_mask = '0;
    logic            m_tmo  = 1'b0;

    always #5 fclk = ~fclk;

    zstall_sync #(
        .NREQ (NREQ),
        .TMO  (TMO)
    ) dut (
        .fclk       (fclk),
        .rst_n      (rst_n),
        .stall_req  (stall_req),
        .stall_gnt  (stall_gnt),
        .clr_tmo    (clr_tmo),
        .cbeg       (cbeg),
        .post_cbeg  (post_cbeg),
        .pre_cend   (pre_cend),
        .cend       (cend),
        .zclk_stall (zclk_stall),
        .stall_tmo  (stall_tmo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %h, expected %h", nm, m_n, act, exp);
    endtask

    // Model: m_n counts edges since reset release; edge n is a boundary when n % 4 == 0.
    // m_cyc counts whole memory cycles the grant has been held.
    always @(posedge fclk or negedge rst_n) begin : model
        int sel;
        bit hit;
        bit bnd;
        if (!rst_n) begin
            m_n    = 0;
            m_mode = M_IDLE;
            m_own  = 0;
            m_cyc  = 0;
            m_mask = '0;
            m_tmo  = 1'b0;
        end else begin
            bnd = ((m_n + 1) % 4) == 0;
            hit = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    sel = -1;
                    for (int i = NREQ - 1; i >= 0; i--)
                        if (stall_req[i] && !m_mask[i]) sel = i;
                    if (sel >= 0) begin
                        m_own  = sel;
                        m_cyc  = 0;
                        m_mode = bnd ? M_HOLD : M_WAIT;
                    end
                end
                M_WAIT: begin
                    if (!stall_req[m_own]) m_mode = M_IDLE;
                    else if (bnd) begin
                        m_mode = M_HOLD;
                        m_cyc  = 0;
                    end
                end
                M_HOLD: begin
                    if (bnd) begin
                        if (!stall_req[m_own]) m_mode = M_GAP;
                        else if (m_cyc + 1 == TMO) begin
                            m_mode = M_GAP;
                            hit    = 1'b1;
                        end else m_cyc = m_cyc + 1;
                    end
                end
                default: begin
                    if (bnd) m_mode = M_IDLE;
                end
            endcase
            for (int i = 0; i < NREQ; i++)
                if (!stall_req[i]) m_mask[i] = 1'b0;
            if (hit) m_mask[m_own] = 1'b1;
            if (hit) m_tmo = 1'b1;
            else if (clr_tmo) m_tmo = 1'b0;
            m_n = m_n + 1;
        end
    end

    function automatic logic [9:0] exp_vec();
        logic [3:0]      s;
        logic [NREQ-1:0] g;
        s = '0;
        g = '0;
        if (m_n > 0) s = 4'b1000 >> ((m_n - 1) % 4);
        if (m_mode == M_HOLD) g[m_own] = 1'b1;
        return {s, (m_mode == M_HOLD || m_mode == M_GAP), g, m_tmo};
    endfunction

    function automatic logic [3:0] strb();
        return {cbeg, post_cbeg, pre_cend, cend};
    endfunction

    always @(posedge fclk) begin
        #1;
        chk("cycle_outputs", 32'({strb(), zclk_stall, stall_gnt, stall_tmo}), 32'(exp_vec()));
        chk("gnt_onehot", 32'($onehot0(stall_gnt)), 32'd1);
    end

    task automatic goto(input int k);
        int guard;
        guard = 0;
        while (m_n < k && guard < 200) begin
            @(negedge fclk);
            guard++;
        end
        if (m_n != k) begin
            n_tot++;
            $display("FAIL goto: at edge %0d, wanted edge %0d", m_n, k);
        end
    endtask

    task automatic do_reset();
        @(negedge fclk);
        rst_n     = 1'b0;
        stall_req = '0;
        clr_tmo   = 1'b0;
        @(negedge fclk);
        @(negedge fclk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge fclk);
        chk("rst_strobes", 32'(strb()), 32'h0);
        chk("rst_stall", 32'(zclk_stall), 32'h0);
        chk("rst_gnt", 32'(stall_gnt), 32'h0);
        chk("rst_tmo", 32'(stall_tmo), 32'h0);
        rst_n = 1'b1;

        // Free-running phase strobes
        goto(1);  chk("run_e1", 32'(strb()), 32'b1000);
        goto(2);  chk("run_e2", 32'(strb()), 32'b0100);
        goto(4);  chk("run_e4", 32'(strb()), 32'b0001);
        goto(5);  chk("run_e5", 32'(strb()), 32'b1000);
        goto(9);  chk("run_e9", 32'(strb()), 32'b1000);
        goto(12); chk("run_e12", 32'({strb(), zclk_stall}), 32'b00010);

        // Single stall on requester 1
        do_reset();
        goto(2);  stall_req = 4'b0010;
        goto(3);  chk("single_e3", 32'({zclk_stall, stall_gnt}), 32'b00000);
        goto(4);  chk("single_e4", 32'({zclk_stall, stall_gnt}), 32'b10010);
        goto(14); stall_req = 4'b0000;
        goto(15); chk("single_e15", 32'({zclk_stall, stall_gnt}), 32'b10010);
        goto(16); chk("single_e16", 32'({zclk_stall, stall_gnt}), 32'b10000);
        goto(19); chk("single_e19", 32'(zclk_stall), 32'd1);
        goto(20); chk("single_e20", 32'(zclk_stall), 32'd0);

        // Two simultaneous requesters: lowest index first
        do_reset();
        goto(1);  stall_req = 4'b0101;
        goto(4);  chk("prio_e4", 32'({zclk_stall, stall_gnt}), 32'b10001);
        goto(9);  stall_req = 4'b0100;
        goto(12); chk("prio_e12", 32'({zclk_stall, stall_gnt}), 32'b10000);
        goto(16); chk("prio_e16", 32'({zclk_stall, stall_gnt}), 32'b00000);
        goto(19); chk("prio_e19", 32'(stall_gnt), 32'b0000);
        goto(20); chk("prio_e20", 32'({zclk_stall, stall_gnt}), 32'b10100);
        goto(25); stall_req = 4'b0000;
        goto(28); chk("prio_e28", 32'({zclk_stall, stall_gnt}), 32'b10000);
        goto(32); chk("prio_e32", 32'(zclk_stall), 32'd0);

        // Timeout, masking until the req drops, clear and set-wins
        do_reset();
        goto(1);  stall_req = 4'b1000;
        goto(4);  chk("tmo_e4", 32'({stall_gnt, stall_tmo}), 32'b10000);
        goto(19); chk("tmo_e19", 32'({stall_gnt, stall_tmo}), 32'b10000);
        goto(20); chk("tmo_e20", 32'({zclk_stall, stall_gnt, stall_tmo}), 32'b100001);
        goto(24); chk("tmo_e24", 32'(zclk_stall), 32'd0);
        goto(40); chk("tmo_masked", 32'({zclk_stall, stall_gnt}), 32'b00000);
        stall_req = 4'b0000;
        goto(41); stall_req = 4'b1000;
        goto(44); chk("tmo_regrant", 32'({stall_gnt, stall_tmo}), 32'b10001);
        clr_tmo = 1'b1;
        goto(45); clr_tmo = 1'b0;
        chk("tmo_cleared", 32'(stall_tmo), 32'd0);
        goto(59); clr_tmo = 1'b1;
        goto(60); clr_tmo = 1'b0;
        chk("tmo_set_wins", 32'({stall_gnt, stall_tmo}), 32'b00001);
        stall_req = 4'b0000;
        goto(64);

        // Withdrawal before the boundary never stalls
        do_reset();
        goto(1);  stall_req = 4'b0001;
        goto(2);  stall_req = 4'b0000;
        goto(4);  chk("wd_e4", 32'({zclk_stall, stall_gnt}), 32'b00000);
        goto(8);  chk("wd_e8", 32'({zclk_stall, stall_gnt}), 32'b00000);

        // Asynchronous reset in the middle of a stall
        do_reset();
        goto(1);  stall_req = 4'b0010;
        goto(6);  chk("mid_pre", 32'({zclk_stall, stall_gnt}), 32'b10010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_stall", 32'(zclk_stall), 32'd0);
        chk("mid_async_gnt", 32'(stall_gnt), 32'd0);
        chk("mid_async_strb", 32'(strb()), 32'd0);
        stall_req = 4'b0000;
        @(negedge fclk);
        @(negedge fclk);
        rst_n = 1'b1;
        goto(1);  chk("mid_restart_e1", 32'(strb()), 32'b1000);
        goto(2);  chk("mid_restart_e2", 32'({strb(), zclk_stall}), 32'b01000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
